i2c_target_regfile: RTL and testbench

I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

---
 rtl/i2c_target_regfile.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing R/W registers and read-only parallel input channels
// Optional SCL/SDA glitch filter enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_regfile #(
    parameter int         REGCOUNT = 24,
    parameter int         PAR_CH   = 1,
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                scl_in,
    input  logic                                sda_in,
    output logic                                sda_oe,
    input  logic [8*(PAR_CH > 0 ? PAR_CH : 1)-1:0] parallel_in,
    output logic [8*REGCOUNT-1:0]               registers_packed,
    output logic                                wr_strobe,
    output logic [7:0]                          wr_index,
    output logic                                busy
);

    localparam logic [8:0] TOTAL = 9'(REGCOUNT + PAR_CH);
    localparam logic [8:0] RCNT  = 9'(REGCOUNT);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl, sda, scl_q, sda_q;
    logic        scl_rise, scl_fall, start, stop;
    logic [7:0]  shift, ptr, ptr_inc, rx_byte, rd_byte;
    logic [2:0]  cnt;
    logic        ack_ph, rw, ptr_ok, ptr_rw, addr_hit;
    logic        sda_oe_nx, busy_nx, commit;
    logic [7:0]  regs [REGCOUNT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // A line follows its synced value only once three consecutive samples agree.
    logic [1:0] scl_hist, sda_hist;
    logic       scl_hold, sda_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_hold <= 1'b1;
            sda_hold <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_hold <= scl;
            sda_hold <= sda;
        end
    end

    assign scl = (scl_hist == {2{scl_sync[1]}}) ? scl_sync[1] : scl_hold;
    assign sda = (sda_hist == {2{sda_sync[1]}}) ? sda_sync[1] : sda_hold;
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

    assign rx_byte  = {shift[6:0], sda};
    assign addr_hit = (rx_byte[7:1] == DEV_ADDR);
    assign ptr_ok   = ({1'b0, rx_byte} < TOTAL);
    assign ptr_rw   = ({1'b0, ptr} < RCNT);
    assign ptr_inc  = ({1'b0, ptr} == TOTAL - 9'd1) ? 8'h00 : ptr + 8'h01;
    assign commit   = (state == WDATA) && scl_rise && (cnt == 3'd7) && ptr_rw;

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < REGCOUNT; i++)
            if (ptr == 8'(i)) rd_byte = regs[i];
        for (int k = 0; k < PAR_CH; k++)
            if (ptr == 8'(REGCOUNT + k)) rd_byte = parallel_in[8*k +: 8];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else if (start) begin
            state_nx = ADDR;
        end else begin
            case (state)
                ADDR:      if (scl_rise && cnt == 3'd7) state_nx = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && ack_ph) state_nx = rw ? RDATA : PTR;
                PTR:       if (scl_rise && cnt == 3'd7) state_nx = ptr_ok ? PTR_ACK : IGNORE;
                PTR_ACK:   if (scl_fall && ack_ph) state_nx = WDATA;
                WDATA:     if (scl_rise && cnt == 3'd7) state_nx = WDATA_ACK;
                WDATA_ACK: if (scl_fall && ack_ph) state_nx = WDATA;
                RDATA:     if (scl_rise && cnt == 3'd7) state_nx = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda)             state_nx = IGNORE;
                    else if (scl_fall && ack_ph)     state_nx = RDATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe_nx = sda_oe;
        busy_nx   = busy;
        if (stop) begin
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b0;
        end else if (start) begin
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b1;
        end else begin
            case (state)
                ADDR: if (scl_rise && cnt == 3'd7 && !addr_hit) busy_nx = 1'b0;
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph)                      sda_oe_nx = 1'b1;
                        else if (state == ADDR_ACK && rw) sda_oe_nx = ~rd_byte[7];
                        else                              sda_oe_nx = 1'b0;
                    end
                end
                RDATA:     if (scl_fall) sda_oe_nx = ~shift[6];
                RDATA_ACK: if (scl_fall) sda_oe_nx = ack_ph ? ~rd_byte[7] : 1'b0;
                default:   sda_oe_nx = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= 8'h00;
            shift     <= 8'h00;
            ptr       <= 8'h00;
            cnt       <= 3'd0;
            ack_ph    <= 1'b0;
            rw        <= 1'b0;
        end else begin
            scl_q     <= scl;
            sda_q     <= sda;
            sda_oe    <= sda_oe_nx;
            busy      <= busy_nx;
            wr_strobe <= commit;
            if (commit) wr_index <= ptr;
            if (start) begin
                cnt    <= 3'd0;
                ack_ph <= 1'b0;
            end else if (!stop) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift  <= rx_byte;
                            cnt    <= cnt + 3'd1;
                            ack_ph <= 1'b0;
                            if (cnt == 3'd7) begin
                                if (state == ADDR)              rw  <= sda;
                                else if (state == PTR && ptr_ok) ptr <= rx_byte;
                                else if (state == WDATA)        ptr <= ptr_inc;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            ack_ph <= ~ack_ph;
                            if (ack_ph && state == ADDR_ACK && rw) shift <= rd_byte;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd7) ptr <= ptr_inc;
                        end
                        if (scl_fall) shift <= {shift[6:0], 1'b0};
                    end
                    RDATA_ACK: begin
                        if (scl_rise && !sda) ack_ph <= 1'b1;
                        if (scl_fall && ack_ph) begin
                            shift  <= rd_byte;
                            ack_ph <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGCOUNT; i++) regs[i] <= 8'h00;
        end else if (commit) begin
            for (int i = 0; i < REGCOUNT; i++)
                if (ptr == 8'(i)) regs[i] <= rx_byte;
        end
    end

    for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
        assign registers_packed[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile (REGCOUNT=24, PAR_CH=1)
module tb_i2c_target_regfile;

    localparam int Q = 8;
    localparam int NREG = 24;
    localparam int TOT = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] par = 8'h00;
    logic sda_line, sda_oe, wr_strobe, busy;
    logic [7:0] wr_index;
    logic [8*NREG-1:0] registers_packed;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regfile #(.REGCOUNT(NREG), .PAR_CH(1), .DEV_ADDR(7'h42)) dut (
        .clock(clock), .reset(reset), .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .parallel_in(par), .registers_packed(registers_packed), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [7:0] last_idx = 8'h00;

    always @(negedge clock) begin
        if (wr_strobe) begin
            strobe_cnt++;
            last_idx = wr_index;
        end
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] mem [NREG];
    int mptr;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] model_pack();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[8*i +: 8] = mem[i];
        return r;
    endfunction

    task automatic wq(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wq(Q);
            m_scl = 1'b1; wq(2*Q);
            m_scl = 1'b0; wq(Q);
        end
        m_sda = 1'b1; wq(Q);
        m_scl = 1'b1; wq(Q);
        ack = ~sda_line; wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wq(Q);
            m_scl = 1'b1; wq(Q);
            b[i] = sda_line; wq(Q);
            m_scl = 1'b0;
        end
        wq(Q);
        m_sda = nack; wq(Q);
        m_scl = 1'b1; wq(2*Q);
        m_scl = 1'b0;
        m_sda = 1'b1; wq(Q);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       aack;
        logic       pack;
        int         strobes;
        logic [7:0] idx;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic a;
        logic [7:0] b, d, p;
        int s0, o0, b0, len, mode, exp_str;
        logic [7:0] exp_b;
        bit hit;

        tbl[0] = '{8'h84, 8'h03, 8'hA5, 1'b1, 1'b1, 1, 8'h03};
        tbl[1] = '{8'h86, 8'h05, 8'h77, 1'b0, 1'b0, 0, 8'h00};
        tbl[2] = '{8'h84, 8'h19, 8'h55, 1'b1, 1'b0, 0, 8'h00};
        tbl[3] = '{8'h84, 8'h18, 8'h99, 1'b1, 1'b1, 0, 8'h00};
        tbl[4] = '{8'h84, 8'h17, 8'h3C, 1'b1, 1'b1, 1, 8'h17};
        tbl[5] = '{8'h84, 8'h00, 8'h7E, 1'b1, 1'b1, 1, 8'h00};
        for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
        mptr = 0;

        wq(3);
        chk("reset_sda_oe", sda_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wr_strobe", wr_strobe, 1'b0);
        chk("reset_wr_index", wr_index, 8'h00);
        chk("reset_regs", registers_packed, '0);
        reset = 1'b0;
        wq(5);

        for (int t = 0; t < 6; t++) begin
            s0 = strobe_cnt;
            o0 = oe_cnt;
            i2c_start();
            chk("busy_after_start", busy, 1'b1);
            send_byte(tbl[t].addr, a);
            chk("addr_ack", a, tbl[t].aack);
            if (a) begin
                send_byte(tbl[t].ptr, a);
                chk("ptr_ack", a, tbl[t].pack);
                if (a) begin
                    send_byte(tbl[t].data, a);
                    chk("data_ack", a, 1'b1);
                end
            end else begin
                chk("busy_after_addr_nack", busy, 1'b0);
                chk("oe_quiet_on_mismatch", oe_cnt - o0, 0);
            end
            i2c_stop();
            wq(4);
            hit = (tbl[t].addr[7:1] == 7'h42) && !tbl[t].addr[0];
            if (hit && tbl[t].ptr < TOT) begin
                mptr = tbl[t].ptr;
                if (mptr < NREG) mem[mptr] = tbl[t].data;
                mptr = (mptr + 1) % TOT;
            end
            chk("strobe_count", strobe_cnt - s0, tbl[t].strobes);
            if (tbl[t].strobes > 0) chk("wr_index", last_idx, tbl[t].idx);
            chk("busy_after_stop", busy, 1'b0);
            chk("regs_table", registers_packed, model_pack());
        end

        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'h84, a); chk("burst_addr_ack", a, 1'b1);
        send_byte(8'h16, a); chk("burst_ptr_ack", a, 1'b1);
        send_byte(8'h11, a); chk("burst_d0_ack", a, 1'b1);
        send_byte(8'h22, a); chk("burst_d1_ack", a, 1'b1);
        send_byte(8'h33, a); chk("burst_ro_ack", a, 1'b1);
        i2c_stop();
        wq(4);
        mem[22] = 8'h11;
        mem[23] = 8'h22;
        mptr = 0;
        chk("burst_strobes", strobe_cnt - s0, 2);
        chk("burst_last_idx", last_idx, 8'd23);
        chk("burst_regs", registers_packed, model_pack());
        i2c_start();
        send_byte(8'h85, a); chk("wrap_rd_addr_ack", a, 1'b1);
        recv_byte(b, 1'b1);
        chk("ptr_wrapped_read", b, 8'h7E);
        i2c_stop();
        mptr = 1;

        par = 8'h5C;
        i2c_start();
        send_byte(8'h84, a); chk("rs_addr_ack", a, 1'b1);
        send_byte(8'h18, a); chk("rs_ptr_ack", a, 1'b1);
        i2c_start();
        send_byte(8'h85, a); chk("rs_rd_addr_ack", a, 1'b1);
        recv_byte(b, 1'b0);
        chk("read_parallel", b, 8'h5C);
        recv_byte(b, 1'b1);
        chk("read_wrap_reg0", b, 8'h7E);
        wq(4);
        chk("released_after_nack", sda_oe, 1'b0);
        i2c_stop();
        wq(4);
        mptr = 1;

        i2c_start();
        send_byte(8'h84, a);
        send_byte(8'h00, a);
        i2c_start();
        send_byte(8'h85, a); chk("rst_rd_addr_ack", a, 1'b1);
        for (int k = 0; k < 60 && !sda_oe; k++) wq(1);
        chk("drive_before_reset", sda_oe, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_sda_oe", sda_oe, 1'b0);
        chk("async_reset_regs", registers_packed, '0);
        chk("async_reset_busy", busy, 1'b0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wq(3);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
        mptr = 0;
        wq(4);
        o0 = oe_cnt;
        b0 = busy_cnt;
        m_scl = 1'b0; wq(Q);
        send_byte(8'h84, a);
        m_scl = 1'b1; wq(Q);
        chk("no_start_oe_quiet", oe_cnt - o0, 0);
        chk("no_start_busy_quiet", busy_cnt - b0, 0);

        b0 = busy_cnt;
        m_sda = 1'b0; wq(2);
        m_sda = 1'b1; wq(12);
`ifdef I2C_TGT_GLITCH_FILTER_EN
        chk("glitch_start", (busy_cnt != b0), 1'b0);
`else
        chk("glitch_start", (busy_cnt != b0), 1'b1);
`endif
        chk("glitch_regs", registers_packed, model_pack());

        for (int it = 0; it < 16; it++) begin
            par = 8'($urandom);
            len = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            p = 8'($urandom_range(0, TOT - 1));
            s0 = strobe_cnt;
            exp_str = 0;
            i2c_start();
            if (mode != 2) begin
                send_byte(8'h84, a); chk("rnd_addr_w_ack", a, 1'b1);
                send_byte(p, a); chk("rnd_ptr_ack", a, 1'b1);
                mptr = p;
            end
            if (mode == 0) begin
                for (int j = 0; j < len; j++) begin
                    d = 8'($urandom);
                    send_byte(d, a);
                    chk("rnd_wdata_ack", a, 1'b1);
                    if (mptr < NREG) begin
                        mem[mptr] = d;
                        exp_str++;
                    end
                    mptr = (mptr + 1) % TOT;
                end
            end else begin
                if (mode == 1) i2c_start();
                send_byte(8'h85, a); chk("rnd_addr_r_ack", a, 1'b1);
                for (int j = 0; j < len; j++) begin
                    recv_byte(b, (j == len - 1));
                    exp_b = (mptr < NREG) ? mem[mptr] : par;
                    chk("rnd_rdata", b, exp_b);
                    mptr = (mptr + 1) % TOT;
                end
            end
            i2c_stop();
            wq(4);
            chk("rnd_strobes", strobe_cnt - s0, exp_str);
            chk("rnd_regs", registers_packed, model_pack());
            chk("rnd_busy", busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
